// File: rtl/rom256_arbiter.sv
// Two-client round-robin arbiter that serialises byte reads onto a 256x8 synchronous ROM macro
// and returns each byte to its requester as a one-cycle response pulse.
module rom256_arbiter #(
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic       rom_cs,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(ROM_LATENCY - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       id_q, id_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rom_cs_q, rom_cs_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic       rsp0_valid_q, rsp0_valid_d;
  logic       rsp1_valid_q, rsp1_valid_d;
  logic [7:0] rsp0_data_q, rsp0_data_d;
  logic [7:0] rsp1_data_q, rsp1_data_d;

  logic       grant_valid_s;
  logic       grant_id_s;

  // Round-robin winner: on a tie the client that was not granted last wins.
  always_comb begin
    grant_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_q;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && (grant_id_s == 1'b0);
  assign req1_ready = (state_q == IDLE) && req1_valid && (grant_id_s == 1'b1);

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rom_cs_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d    = ACCESS;
          last_d     = grant_id_s;
          id_d       = grant_id_s;
          rom_cs_d   = 1'b1;
          rom_addr_d = grant_id_s ? req1_addr : req0_addr;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // The macro output is valid on the last WAIT cycle; capture it for the owner.
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          if (id_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = rom_dout;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = rom_dout;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= 2'd0;
      rom_cs_q     <= 1'b0;
      rom_addr_q   <= 8'h00;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 8'h00;
      rsp1_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rom_cs_q     <= rom_cs_d;
      rom_addr_q   <= rom_addr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rom_cs     = rom_cs_q;
  assign rom_addr   = rom_addr_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_rom256_arbiter.sv
// Bench for rom256_arbiter: one instance at ROM latency 1 and one at latency 3, each checked
// every cycle against a transaction-level model of grant, ROM strobe and response timing.
module tb_rom256_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            rst_n;
  logic [1:0][1:0]       rv, rdy, pv;
  logic [1:0][1:0][7:0]  rq, pd;
  logic [1:0]            cs;
  logic [1:0][7:0]       ra, rd;
  logic [7:0]            rom_pipe [2][3];

  rom256_arbiter #(.ROM_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req0_valid(rv[0][0]), .req0_addr(rq[0][0]), .req0_ready(rdy[0][0]),
    .rsp0_valid(pv[0][0]), .rsp0_data(pd[0][0]),
    .req1_valid(rv[0][1]), .req1_addr(rq[0][1]), .req1_ready(rdy[0][1]),
    .rsp1_valid(pv[0][1]), .rsp1_data(pd[0][1]),
    .rom_cs(cs[0]), .rom_addr(ra[0]), .rom_dout(rd[0])
  );

  rom256_arbiter #(.ROM_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req0_valid(rv[1][0]), .req0_addr(rq[1][0]), .req0_ready(rdy[1][0]),
    .rsp0_valid(pv[1][0]), .rsp0_data(pd[1][0]),
    .req1_valid(rv[1][1]), .req1_addr(rq[1][1]), .req1_ready(rdy[1][1]),
    .rsp1_valid(pv[1][1]), .rsp1_data(pd[1][1]),
    .rom_cs(cs[1]), .rom_addr(ra[1]), .rom_dout(rd[1])
  );

  // ROM macro model: dout = addr ^ 0xA5, valid ROM_LATENCY edges after cs is sampled.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs[k]) rom_pipe[k][0] <= ra[k] ^ 8'hA5;
      rom_pipe[k][1] <= rom_pipe[k][0];
      rom_pipe[k][2] <= rom_pipe[k][1];
    end
  end
  assign rd[0] = rom_pipe[0][0];
  assign rd[1] = rom_pipe[1][2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: cycle numbers count rising edges seen so far.
  int         m_last    [2] = '{1, 1};
  int         idle_from [2] = '{0, 0};
  int         acc_edge  [2] = '{-1, -1};
  int         rsp_cycle [2] = '{-1, -1};
  bit         pending   [2] = '{1'b0, 1'b0};
  int         m_id      [2] = '{0, 0};
  logic [7:0] m_addr    [2] = '{8'h00, 8'h00};
  logic [7:0] m_data    [2][2];
  logic [1:0][1:0] took;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_data[k][0] = 8'h00;
      m_data[k][1] = 8'h00;
    end
    took = '0;
  end

  // Per-cycle expectation, comparison and model update, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] e_rdy, e_pv;
      logic       e_cs;
      int         g;
      e_rdy = 2'b00;
      if (cyc >= idle_from[k]) begin
        if (rv[k][0] && rv[k][1]) e_rdy = (m_last[k] == 1) ? 2'b01 : 2'b10;
        else e_rdy = rv[k];
      end
      e_pv = 2'b00;
      if (pending[k] && cyc == rsp_cycle[k]) begin
        m_data[k][m_id[k]] = m_addr[k] ^ 8'hA5;
        e_pv[m_id[k]] = 1'b1;
        pending[k] = 1'b0;
        n_rsp++;
      end
      e_cs = (cyc == acc_edge[k]);
      if (chk_en) begin
        for (int j = 0; j < 2; j++) begin
          check($sformatf("i%0d_ready%0d", k, j), 32'(rdy[k][j]), 32'(e_rdy[j]));
          check($sformatf("i%0d_rsp_valid%0d", k, j), 32'(pv[k][j]), 32'(e_pv[j]));
          check($sformatf("i%0d_rsp_data%0d", k, j), 32'(pd[k][j]), 32'(m_data[k][j]));
        end
        check($sformatf("i%0d_rom_cs", k), 32'(cs[k]), 32'(e_cs));
        check($sformatf("i%0d_rom_addr", k), 32'(ra[k]), 32'(m_addr[k]));
      end
      took[k] = rv[k] & rdy[k] & {2{rst_n[k]}};
      if (!rst_n[k]) begin
        m_last[k]    = 1;
        idle_from[k] = cyc + 1;
        acc_edge[k]  = -1;
        pending[k]   = 1'b0;
        m_addr[k]    = 8'h00;
        m_data[k][0] = 8'h00;
        m_data[k][1] = 8'h00;
      end else if (e_rdy != 2'b00) begin
        g            = e_rdy[1] ? 1 : 0;
        m_last[k]    = g;
        m_id[k]      = g;
        m_addr[k]    = rq[k][g];
        acc_edge[k]  = cyc + 1;
        rsp_cycle[k] = cyc + lat_of(k) + 2;
        idle_from[k] = rsp_cycle[k];
        pending[k]   = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random client behaviour obeying hold-until-ready, with occasional withdrawals and resets.
  task automatic drive_random(input int rst_permille);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (rv[k][j] && !took[k][j]) begin
          if ($urandom_range(0, 99) < 6) rv[k][j] = 1'b0;
        end else if ($urandom_range(0, 99) < 60) begin
          rv[k][j] = 1'b1;
          rq[k][j] = 8'($urandom);
        end else begin
          rv[k][j] = 1'b0;
        end
      end
      rst_n[k] = ($urandom_range(0, 999) < rst_permille) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    int t;
    rst_n = 2'b00;
    rv    = '0;
    rq    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Tie from reset on both instances: client 0 at 0x10 first, then client 1 at 0x20.
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b11;
      rq[k][0] = 8'h10;
      rq[k][1] = 8'h20;
    end
    rst_n = 2'b11;
    t = 0;
    while (rv != '0 && t < 60) begin
      step();
      for (int k = 0; k < 2; k++) rv[k] = rv[k] & ~took[k];
      t++;
    end
    check("tie_timeout", 32'(t < 60), 32'd1);
    repeat (6) step();
    check("tie_i0_data0", 32'(pd[0][0]), 32'h0B5);
    check("tie_i0_data1", 32'(pd[0][1]), 32'h085);
    check("tie_i1_data0", 32'(pd[1][0]), 32'h0B5);
    check("tie_i1_data1", 32'(pd[1][1]), 32'h085);

    // Client 0 reads 0x33 on the latency-1 instance; reset lands in its WAIT cycle.
    rv[0][0] = 1'b1;
    rq[0][0] = 8'h33;
    t = 0;
    while (!took[0][0] && t < 20) begin
      step();
      t++;
    end
    check("mid_rst_accept", 32'(t < 20), 32'd1);
    rv[0][0] = 1'b0;
    step();
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    check("mid_rst_data0", 32'(pd[0][0]), 32'h000);
    check("mid_rst_cs", 32'(cs[0]), 32'd0);
    rv[0] = 2'b11;
    rq[0][0] = 8'h44;
    rq[0][1] = 8'h55;
    step();
    check("post_rst_tie", 32'(took[0]), 32'h1);
    rv[0] = 2'b00;
    repeat (4) step();

    for (int i = 0; i < 3000; i++) begin
      drive_random(4);
      step();
    end
    rv    = '0;
    rst_n = 2'b11;
    repeat (8) step();
    check("activity", 32'(n_rsp > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
